// File: rtl/elevator_ctrl.sv
// SCAN elevator car controller: latches calls, moves one floor per TRAVEL_CYC cycles, dwells DOOR_CYC cycles.
// All outputs are registered; requests are acted on in the same edge they are sampled.
module elevator_ctrl #(
  parameter int NFLOORS    = 4,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic                       CK,
  input  logic                       CLR_N,
  input  logic [NFLOORS-1:0]         REQ,
  output logic [$clog2(NFLOORS)-1:0] FLOOR,
  output logic                       UP,
  output logic                       DN,
  output logic                       DOOR,
  output logic [NFLOORS-1:0]         PEND,
  output logic [1:0]                 STATE
);

  localparam int FW  = $clog2(NFLOORS);
  localparam int TTW = $clog2(TRAVEL_CYC + 1);
  localparam int DTW = $clog2(DOOR_CYC + 1);
  localparam logic [TTW-1:0] TRAV_LD = TTW'(TRAVEL_CYC - 1);
  localparam logic [DTW-1:0] DOOR_LD = DTW'(DOOR_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DN   = 2'd2,
    S_DOOR = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [FW-1:0]      floor, floor_nx, next_floor;
  logic [NFLOORS-1:0] pend, pend_nx, eff;
  logic [TTW-1:0]     ttmr, ttmr_nx;
  logic [DTW-1:0]     dtmr, dtmr_nx;
  logic               last_up, last_up_nx;
  logic               ahead_up, ahead_dn, beyond_up, beyond_dn;

  assign eff        = pend | REQ;
  assign next_floor = (state == S_DN) ? floor - FW'(1) : floor + FW'(1);

  // "beyond" looks past the floor the car is about to reach, for the stay-moving decision
  always_comb begin
    ahead_up  = 1'b0;
    ahead_dn  = 1'b0;
    beyond_up = 1'b0;
    beyond_dn = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (eff[i]) begin
        if (i > int'(floor))     ahead_up  = 1'b1;
        if (i < int'(floor))     ahead_dn  = 1'b1;
        if (i > int'(floor) + 1) beyond_up = 1'b1;
        if (i < int'(floor) - 1) beyond_dn = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    floor_nx   = floor;
    pend_nx    = eff;
    ttmr_nx    = ttmr;
    dtmr_nx    = dtmr;
    last_up_nx = last_up;
    case (state)
      S_IDLE: begin
        if (eff[floor]) begin
          state_nx       = S_DOOR;
          pend_nx[floor] = 1'b0;
          dtmr_nx        = DOOR_LD;
        end else if (last_up ? ahead_up : ahead_dn) begin
          state_nx = last_up ? S_UP : S_DN;
          ttmr_nx  = TRAV_LD;
        end else if (last_up ? ahead_dn : ahead_up) begin
          state_nx   = last_up ? S_DN : S_UP;
          last_up_nx = ~last_up;
          ttmr_nx    = TRAV_LD;
        end
      end
      S_UP, S_DN: begin
        if (ttmr != '0) begin
          ttmr_nx = ttmr - TTW'(1);
        end else begin
          floor_nx = next_floor;
          ttmr_nx  = TRAV_LD;
          if (eff[next_floor]) begin
            state_nx            = S_DOOR;
            pend_nx[next_floor] = 1'b0;
            dtmr_nx             = DOOR_LD;
          end else if (!((state == S_UP) ? beyond_up : beyond_dn)) begin
            state_nx = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        // A call for the open floor is absorbed and holds the door instead
        pend_nx[floor] = 1'b0;
        if (REQ[floor]) begin
          dtmr_nx = DOOR_LD;
        end else if (dtmr == '0) begin
          state_nx = S_IDLE;
        end else begin
          dtmr_nx = dtmr - DTW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge CLR_N) begin
    if (!CLR_N) begin
      state   <= S_IDLE;
      floor   <= '0;
      pend    <= '0;
      ttmr    <= '0;
      dtmr    <= '0;
      last_up <= 1'b1;
    end else begin
      state   <= state_nx;
      floor   <= floor_nx;
      pend    <= pend_nx;
      ttmr    <= ttmr_nx;
      dtmr    <= dtmr_nx;
      last_up <= last_up_nx;
    end
  end

  assign FLOOR = floor;
  assign PEND  = pend;
  assign STATE = state;
  assign UP    = (state == S_UP);
  assign DN    = (state == S_DN);
  assign DOOR  = (state == S_DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (4 floors, travel 4, door 3); observations packed as
// {STATE, FLOOR, UP, DN, DOOR, PEND} and compared against hand-derived values.
module tb_elevator_ctrl;

  logic       CK;
  logic       CLR_N;
  logic [3:0] REQ;
  logic [1:0] FLOOR;
  logic       UP, DN, DOOR;
  logic [3:0] PEND;
  logic [1:0] STATE;
  logic [10:0] obs;

  int vectors;
  int miscompares;

  elevator_ctrl #(.NFLOORS(4), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
    .CK(CK), .CLR_N(CLR_N), .REQ(REQ), .FLOOR(FLOOR),
    .UP(UP), .DN(DN), .DOOR(DOOR), .PEND(PEND), .STATE(STATE)
  );

  assign obs = {STATE, FLOOR, UP, DN, DOOR, PEND};

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    REQ = v;
    step(1);
    REQ = 4'b0000;
  endtask

  task automatic do_reset;
    REQ   = 4'b0000;
    CLR_N = 1'b0;
    #2;
    CLR_N = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if (obs !== {2'd0, 2'd0, 3'b000, 4'b0000}) begin
      miscompares++; $display("FAIL reset_state got=%b want=%b", obs, {2'd0, 2'd0, 3'b000, 4'b0000});
    end
    pulse(4'b1000);
    step(8);
    pulse(4'b0010);
    vectors++;
    if (obs !== {2'd1, 2'd2, 3'b100, 4'b1010}) begin
      miscompares++; $display("FAIL pre_reset got=%b want=%b", obs, {2'd1, 2'd2, 3'b100, 4'b1010});
    end
    #3;
    CLR_N = 1'b0;
    #1;
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++; $display("FAIL async_reset got=%b want=%b", obs, 11'd0);
    end
    #2;
    CLR_N = 1'b1;
    step(1);
    vectors++;
    if (obs !== 11'd0) begin
      miscompares++; $display("FAIL post_release got=%b want=%b", obs, 11'd0);
    end
  endtask

  task automatic test_door_here;
    pulse(4'b0001);
    vectors++;
    if (obs !== {2'd3, 2'd0, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL door_open got=%b want=%b", obs, {2'd3, 2'd0, 3'b001, 4'b0000});
    end
    step(2);
    vectors++;
    if (obs !== {2'd3, 2'd0, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL door_hold got=%b want=%b", obs, {2'd3, 2'd0, 3'b001, 4'b0000});
    end
    step(1);
    vectors++;
    if (obs !== {2'd0, 2'd0, 3'b000, 4'b0000}) begin
      miscompares++; $display("FAIL door_close got=%b want=%b", obs, {2'd0, 2'd0, 3'b000, 4'b0000});
    end
  endtask

  task automatic test_travel;
    pulse(4'b1000);
    vectors++;
    if (obs !== {2'd1, 2'd0, 3'b100, 4'b1000}) begin
      miscompares++; $display("FAIL travel_start got=%b want=%b", obs, {2'd1, 2'd0, 3'b100, 4'b1000});
    end
    step(3);
    vectors++;
    if (obs !== {2'd1, 2'd0, 3'b100, 4'b1000}) begin
      miscompares++; $display("FAIL travel_n3 got=%b want=%b", obs, {2'd1, 2'd0, 3'b100, 4'b1000});
    end
    step(1);
    vectors++;
    if (obs !== {2'd1, 2'd1, 3'b100, 4'b1000}) begin
      miscompares++; $display("FAIL travel_f1 got=%b want=%b", obs, {2'd1, 2'd1, 3'b100, 4'b1000});
    end
    step(4);
    vectors++;
    if (obs !== {2'd1, 2'd2, 3'b100, 4'b1000}) begin
      miscompares++; $display("FAIL travel_f2 got=%b want=%b", obs, {2'd1, 2'd2, 3'b100, 4'b1000});
    end
    step(4);
    vectors++;
    if (obs !== {2'd3, 2'd3, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL travel_f3_door got=%b want=%b", obs, {2'd3, 2'd3, 3'b001, 4'b0000});
    end
    step(2);
    vectors++;
    if (obs !== {2'd3, 2'd3, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL travel_door_hold got=%b want=%b", obs, {2'd3, 2'd3, 3'b001, 4'b0000});
    end
    step(1);
    vectors++;
    if (obs !== {2'd0, 2'd3, 3'b000, 4'b0000}) begin
      miscompares++; $display("FAIL travel_idle_top got=%b want=%b", obs, {2'd0, 2'd3, 3'b000, 4'b0000});
    end
  endtask

  task automatic test_scan;
    do_reset();
    pulse(4'b1000);
    step(4);
    pulse(4'b0101);
    vectors++;
    if (obs !== {2'd1, 2'd1, 3'b100, 4'b1101}) begin
      miscompares++; $display("FAIL scan_latch got=%b want=%b", obs, {2'd1, 2'd1, 3'b100, 4'b1101});
    end
    step(3);
    vectors++;
    if (obs !== {2'd3, 2'd2, 3'b001, 4'b1001}) begin
      miscompares++; $display("FAIL scan_stop_f2 got=%b want=%b", obs, {2'd3, 2'd2, 3'b001, 4'b1001});
    end
    step(3);
    vectors++;
    if (obs !== {2'd0, 2'd2, 3'b000, 4'b1001}) begin
      miscompares++; $display("FAIL scan_idle_f2 got=%b want=%b", obs, {2'd0, 2'd2, 3'b000, 4'b1001});
    end
    step(1);
    vectors++;
    if (obs !== {2'd1, 2'd2, 3'b100, 4'b1001}) begin
      miscompares++; $display("FAIL scan_resume_up got=%b want=%b", obs, {2'd1, 2'd2, 3'b100, 4'b1001});
    end
    step(4);
    vectors++;
    if (obs !== {2'd3, 2'd3, 3'b001, 4'b0001}) begin
      miscompares++; $display("FAIL scan_stop_f3 got=%b want=%b", obs, {2'd3, 2'd3, 3'b001, 4'b0001});
    end
    step(4);
    vectors++;
    if (obs !== {2'd2, 2'd3, 3'b010, 4'b0001}) begin
      miscompares++; $display("FAIL scan_reverse got=%b want=%b", obs, {2'd2, 2'd3, 3'b010, 4'b0001});
    end
    step(4);
    vectors++;
    if (obs !== {2'd2, 2'd2, 3'b010, 4'b0001}) begin
      miscompares++; $display("FAIL scan_pass_f2 got=%b want=%b", obs, {2'd2, 2'd2, 3'b010, 4'b0001});
    end
    step(4);
    vectors++;
    if (obs !== {2'd2, 2'd1, 3'b010, 4'b0001}) begin
      miscompares++; $display("FAIL scan_no_stop_f1 got=%b want=%b", obs, {2'd2, 2'd1, 3'b010, 4'b0001});
    end
    step(4);
    vectors++;
    if (obs !== {2'd3, 2'd0, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL scan_stop_f0 got=%b want=%b", obs, {2'd3, 2'd0, 3'b001, 4'b0000});
    end
    step(3);
    vectors++;
    if (obs !== {2'd0, 2'd0, 3'b000, 4'b0000}) begin
      miscompares++; $display("FAIL scan_final_idle got=%b want=%b", obs, {2'd0, 2'd0, 3'b000, 4'b0000});
    end
  endtask

  task automatic test_dwell;
    do_reset();
    pulse(4'b0100);
    step(8);
    vectors++;
    if (obs !== {2'd3, 2'd2, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL dwell_arrive got=%b want=%b", obs, {2'd3, 2'd2, 3'b001, 4'b0000});
    end
    pulse(4'b0100);
    vectors++;
    if (obs !== {2'd3, 2'd2, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL dwell_no_latch got=%b want=%b", obs, {2'd3, 2'd2, 3'b001, 4'b0000});
    end
    step(2);
    vectors++;
    if (obs !== {2'd3, 2'd2, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL dwell_extended got=%b want=%b", obs, {2'd3, 2'd2, 3'b001, 4'b0000});
    end
    step(1);
    vectors++;
    if (obs !== {2'd0, 2'd2, 3'b000, 4'b0000}) begin
      miscompares++; $display("FAIL dwell_close got=%b want=%b", obs, {2'd0, 2'd2, 3'b000, 4'b0000});
    end
  endtask

  task automatic test_sweep;
    pulse(4'b1001);
    vectors++;
    if (obs !== {2'd1, 2'd2, 3'b100, 4'b1001}) begin
      miscompares++; $display("FAIL sweep_up_first got=%b want=%b", obs, {2'd1, 2'd2, 3'b100, 4'b1001});
    end
    step(4);
    vectors++;
    if (obs !== {2'd3, 2'd3, 3'b001, 4'b0001}) begin
      miscompares++; $display("FAIL sweep_top_clear got=%b want=%b", obs, {2'd3, 2'd3, 3'b001, 4'b0001});
    end
    step(4);
    vectors++;
    if (obs !== {2'd2, 2'd3, 3'b010, 4'b0001}) begin
      miscompares++; $display("FAIL sweep_down got=%b want=%b", obs, {2'd2, 2'd3, 3'b010, 4'b0001});
    end
    step(12);
    vectors++;
    if (obs !== {2'd3, 2'd0, 3'b001, 4'b0000}) begin
      miscompares++; $display("FAIL sweep_bottom_clear got=%b want=%b", obs, {2'd3, 2'd0, 3'b001, 4'b0000});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    REQ         = 4'b0000;
    CLR_N       = 1'b0;
    #12;
    test_reset();
    test_door_here();
    test_travel();
    test_scan();
    test_dwell();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
